// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the 8N1 UART receiver
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_t;

  localparam int DATA_BITS = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser for the asynchronous rx pin, idles high
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_axis.sv
// rtl/uart_rx_axis.sv - 8N1 UART receiver feeding a single-entry tvalid/tready/tdata slot
// Optional build macro UART_RX_SYNC_EN inserts a 2-flop synchroniser on rx.
module uart_rx_axis
  import uart_rx_pkg::*;
#(
  parameter int cycles_per_bit = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       tready,
  output logic       tvalid,
  output logic [7:0] tdata,
  output logic       overflow
);

  localparam int TW = $clog2(cycles_per_bit);
  localparam logic [TW-1:0] BIT_LAST  = TW'(cycles_per_bit - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(cycles_per_bit / 2 - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

  logic rx_s;

`ifdef UART_RX_SYNC_EN
  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rx_s)
  );
`else
  assign rx_s = rx;
`endif

  uart_rx_state_t       state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tvalid_q, tvalid_d;
  logic [7:0]           tdata_q, tdata_d;
  logic                 overflow_q, overflow_d;
  logic                 byte_done;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    tvalid_d   = tvalid_q & ~tready;
    tdata_d    = tdata_q;
    overflow_d = 1'b0;
    byte_done  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          timer_d = '0;
        end
      end
      START: begin
        if (timer_q == HALF_LAST) begin
          timer_d = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DATA: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (idx_q == IDX_LAST) state_d = STOP;
          else                   idx_d   = idx_q + 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      STOP: begin
        // Leave at mid-stop so a start bit right after a one-bit stop is caught.
        if (timer_q == BIT_LAST) begin
          timer_d   = '0;
          state_d   = IDLE;
          byte_done = rx_s;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (byte_done) begin
      if (!tvalid_q || tready) begin
        tdata_d  = shift_q;
        tvalid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      tvalid_q   <= 1'b0;
      tdata_q    <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
      overflow_q <= overflow_d;
    end
  end

  assign tvalid   = tvalid_q;
  assign tdata    = tdata_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_axis.sv
// tb/tb_uart_rx_axis.sv - directed self-checking bench for uart_rx_axis
module tb_uart_rx_axis;

  localparam int CPB = 434;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       tready;
  logic       tvalid;
  logic [7:0] tdata;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;
  int ovf_cnt = 0;
  int hs_cnt  = 0;
  logic [7:0] hs_data = 8'h00;

  uart_rx_axis #(.cycles_per_bit(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .tready   (tready),
    .tvalid   (tvalid),
    .tdata    (tdata),
    .overflow (overflow)
  );

  always #10 clk = ~clk;

  // Inputs change 1 ns after posedge, so the negedge view is what the next edge uses.
  always @(negedge clk) begin
    if (overflow === 1'b1) ovf_cnt++;
    if (tvalid === 1'b1 && tready === 1'b1) begin
      hs_cnt++;
      hs_data = tdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) tick();
    end
    rx = stop_bit;
    repeat (CPB) tick();
    rx = 1'b1;
  endtask

  initial begin
    rst    = 1'b1;
    rx     = 1'b1;
    tready = 1'b0;
    repeat (3) tick();
    chk("reset_tvalid", 32'(tvalid), 32'h0);
    chk("reset_tdata", 32'(tdata), 32'h00);
    chk("reset_overflow", 32'(overflow), 32'h0);
    rst = 1'b0;

    repeat (5) tick();
    chk("idle_tvalid", 32'(tvalid), 32'h0);
    chk("idle_overflow_count", 32'(ovf_cnt), 32'h0);

    send_frame(8'h4D, 1'b1);
    chk("f1_tvalid", 32'(tvalid), 32'h1);
    chk("f1_tdata", 32'(tdata), 32'h4D);
    tready = 1'b1;
    tick();
    tready = 1'b0;
    chk("f1_after_hs_tvalid", 32'(tvalid), 32'h0);
    chk("f1_hs_count", 32'(hs_cnt), 32'd1);
    chk("f1_hs_data", 32'(hs_data), 32'h4D);
    chk("f1_no_overflow", 32'(ovf_cnt), 32'h0);

    repeat (20) tick();
    send_frame(8'h4D, 1'b1);
    chk("b2b_first_tvalid", 32'(tvalid), 32'h1);
    chk("b2b_first_tdata", 32'(tdata), 32'h4D);
    send_frame(8'h4D, 1'b1);
    chk("b2b_overflow_pulses", 32'(ovf_cnt), 32'd1);
    chk("b2b_tdata_held", 32'(tdata), 32'h4D);
    chk("b2b_tvalid_held", 32'(tvalid), 32'h1);
    chk("b2b_overflow_now", 32'(overflow), 32'h0);
    tready = 1'b1;
    tick();
    tready = 1'b0;
    chk("b2b_drain_tvalid", 32'(tvalid), 32'h0);
    chk("b2b_hs_count", 32'(hs_cnt), 32'd2);

    repeat (20) tick();
    rx = 1'b0;
    repeat (100) tick();
    rx = 1'b1;
    repeat (600) tick();
    chk("glitch_tvalid", 32'(tvalid), 32'h0);
    chk("glitch_state_idle", 32'(dut.state_q), 32'(uart_rx_pkg::IDLE));

    send_frame(8'hA5, 1'b0);
    repeat (1000) tick();
    chk("framing_tvalid", 32'(tvalid), 32'h0);
    chk("framing_overflow", 32'(ovf_cnt), 32'd1);
    send_frame(8'h3C, 1'b1);
    chk("post_framing_tvalid", 32'(tvalid), 32'h1);
    chk("post_framing_tdata", 32'(tdata), 32'h3C);

    repeat (20) tick();
    rx = 1'b0;
    repeat (CPB * 3) tick();
    rst = 1'b1;
    #1;
    chk("midrst_tvalid", 32'(tvalid), 32'h0);
    chk("midrst_tdata", 32'(tdata), 32'h00);
    chk("midrst_overflow", 32'(overflow), 32'h0);
    rx = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (20) tick();
    chk("midrst_idle_tvalid", 32'(tvalid), 32'h0);
    send_frame(8'hFF, 1'b1);
    chk("ff_tvalid", 32'(tvalid), 32'h1);
    chk("ff_tdata", 32'(tdata), 32'hFF);
    tready = 1'b1;
    tick();
    tready = 1'b0;
    chk("ff_hs_data", 32'(hs_data), 32'hFF);
    chk("ff_after_hs_tvalid", 32'(tvalid), 32'h0);
    chk("final_overflow_count", 32'(ovf_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
